// File: rtl/udp_oe_pkg.sv
// Shared constants, register map and per-channel state layout for the UOE CSR block.
package udp_oe_pkg;

    localparam logic [3:0]  DFH_FEATURE_TYPE = 4'h1;
    localparam logic [7:0]  DFH_VERSION      = 8'h01;
    localparam logic [3:0]  DFH_FEATURE_REV  = 4'h1;
    localparam logic [11:0] DFH_FEATURE_ID   = 12'h0A5;
    localparam logic [63:0] DFH_ID_LO        = 64'hB3A8_0F2C_5D61_40E7;
    localparam logic [63:0] DFH_ID_HI        = 64'h7C1E_9A44_2F0B_4D53;
    localparam logic [63:0] DFH_WORD3        = 64'h18;
    localparam logic [63:0] DFH_WORD4        = 64'h20;

    localparam int unsigned CSR_DFH          = 0;
    localparam int unsigned CSR_ID_LO        = 1;
    localparam int unsigned CSR_ID_HI        = 2;
    localparam int unsigned CSR_W3           = 3;
    localparam int unsigned CSR_W4           = 4;
    localparam int unsigned CSR_SCRATCH      = 5;
    localparam int unsigned CSR_NUM_CHAN     = 6;
    localparam int unsigned CSR_FPGA_MAC     = 7;
    localparam int unsigned NUM_NET_REGS     = 9;

    localparam int unsigned CSR_CHAN_INFO    = 0;
    localparam int unsigned CSR_CHAN_RESET   = 1;
    localparam int unsigned CSR_CHAN_STATUS  = 2;
    localparam int unsigned CSR_CHAN_MISC    = 3;
    localparam int unsigned CSR_CHAN_ERR     = 4;
    localparam int unsigned CSR_CHAN_TX_CNT  = 5;
    localparam int unsigned CSR_CHAN_RX_CNT  = 6;

    localparam logic [63:0] REG_RD_BADADDR_DATA = 64'h0BAD_ADD0_0BAD_ADD0;

    // Timer and error fields are sized for the largest legal parameters.
    localparam int unsigned RST_TMR_W = 16;
    typedef logic [RST_TMR_W-1:0] rst_tmr_t;
    localparam rst_tmr_t TMR_ONE = rst_tmr_t'(1);

    typedef struct packed {
        logic [63:0]             misc_ctrl;
        logic [63:0]             err;
        logic [31:0]             tx_cnt;
        logic [31:0]             rx_cnt;
        logic [2:0][RST_TMR_W-1:0] rst_timer;
    } chan_csr_t;

    function automatic logic [63:0] be_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                             input logic [7:0] be);
        logic [63:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 8; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] cnt_next(input logic [31:0] cnt, input logic clr, input logic pulse);
        if (clr) return pulse ? 32'd1 : 32'd0;
        if (pulse && cnt != '1) return cnt + 32'd1;
        return cnt;
    endfunction

    function automatic logic [63:0] dfh_header(input logic [23:0] regsz_bytes);
        return {DFH_FEATURE_TYPE, DFH_VERSION, 11'd0, 1'b1, regsz_bytes, DFH_FEATURE_REV, DFH_FEATURE_ID};
    endfunction

endpackage

// File: rtl/udp_oe_chan_csr.sv
// One UOE channel register bank: reset pulse timers, control, sticky errors, packet counters.
module udp_oe_chan_csr
    import udp_oe_pkg::*;
#(
    parameter int CHAN_IDX         = 0,
    parameter int NUM_CHAN         = 2,
    parameter int STRIDE_WORDS     = 16,
    parameter int OFF_W            = 4,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int ERR_W            = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [63:0]      wdata_i,
    input  logic [7:0]       be_i,
    input  logic [31:0]      tx_status_i,
    input  logic [31:0]      rx_status_i,
    input  logic [ERR_W-1:0] err_event_i,
    input  logic             tx_pkt_i,
    input  logic             rx_pkt_i,
    output logic [63:0]      rdata_o,
    output logic             csr_rst_o,
    output logic             rx_rst_o,
    output logic             tx_rst_o,
    output logic [63:0]      misc_ctrl_o
);

    localparam rst_tmr_t    TMR_LOAD = rst_tmr_t'(RST_PULSE_CYCLES);
    localparam logic        EOL      = (CHAN_IDX == NUM_CHAN - 1);
    localparam logic [63:0] INFO     = {47'd0, EOL, 8'(CHAN_IDX), 8'(STRIDE_WORDS)};

    chan_csr_t   st_q, st_d;
    logic [31:0] off32;
    logic [2:0]  rst_lvl;
    logic [63:0] w1c;

    assign off32 = 32'(off_i);

    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            rst_lvl[k] = (st_q.rst_timer[k] != '0);
        end
    end

    assign csr_rst_o   = rst_lvl[0];
    assign rx_rst_o    = rst_lvl[1];
    assign tx_rst_o    = rst_lvl[2];
    assign misc_ctrl_o = st_q.misc_ctrl;

    always_comb begin
        st_d = st_q;
        for (int unsigned k = 0; k < 3; k++) begin
            if (rst_lvl[k]) st_d.rst_timer[k] = st_q.rst_timer[k] - TMR_ONE;
            if (wr_i && off32 == CSR_CHAN_RESET && wdata_i[k]) st_d.rst_timer[k] = TMR_LOAD;
        end
        if (wr_i && off32 == CSR_CHAN_MISC) st_d.misc_ctrl = be_merge(st_q.misc_ctrl, wdata_i, be_i);
        // Event OR'd after the clear so a same-cycle set wins.
        w1c       = (wr_i && off32 == CSR_CHAN_ERR) ? wdata_i : '0;
        st_d.err  = (st_q.err & ~w1c) | 64'(err_event_i);
        st_d.tx_cnt = cnt_next(st_q.tx_cnt, wr_i && off32 == CSR_CHAN_TX_CNT, tx_pkt_i);
        st_d.rx_cnt = cnt_next(st_q.rx_cnt, wr_i && off32 == CSR_CHAN_RX_CNT, rx_pkt_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st_q <= '0;
        else       st_q <= st_d;
    end

    always_comb begin
        rdata_o = REG_RD_BADADDR_DATA;
        case (off32)
            CSR_CHAN_INFO:   rdata_o = INFO;
            CSR_CHAN_RESET:  rdata_o = {61'd0, rst_lvl[2], rst_lvl[1], rst_lvl[0]};
            CSR_CHAN_STATUS: rdata_o = {tx_status_i, rx_status_i};
            CSR_CHAN_MISC:   rdata_o = st_q.misc_ctrl;
            CSR_CHAN_ERR:    rdata_o = st_q.err;
            CSR_CHAN_TX_CNT: rdata_o = {32'd0, st_q.tx_cnt};
            CSR_CHAN_RX_CNT: rdata_o = {32'd0, st_q.rx_cnt};
            default:         rdata_o = REG_RD_BADADDR_DATA;
        endcase
    end

endmodule

// File: rtl/udp_oe_csr_mchan.sv
// UOE CSR top: common network registers plus NUM_CHAN channel banks behind one AVMM slave.
module udp_oe_csr_mchan
    import udp_oe_pkg::*;
#(
    parameter int NUM_CHAN          = 2,
    parameter int CHAN_BASE_WORD    = 'h20,
    parameter int CHAN_STRIDE_WORDS = 'h10,
    parameter int ADDR_W            = 13,
    parameter int RST_PULSE_CYCLES  = 16,
    parameter int ERR_W             = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       avmm_address,
    input  logic                    avmm_read,
    input  logic                    avmm_write,
    input  logic [63:0]             avmm_writedata,
    input  logic [7:0]              avmm_byteenable,
    output logic                    avmm_waitrequest,
    output logic [63:0]             avmm_readdata,
    output logic                    avmm_readdatavalid,
    output logic [47:0]             fpga_mac_adr,
    output logic [47:0]             host_mac_adr,
    output logic [31:0]             fpga_ip_adr,
    output logic [31:0]             host_ip_adr,
    output logic [31:0]             fpga_netmask,
    output logic [15:0]             fpga_udp_port,
    output logic [15:0]             host_udp_port,
    output logic [15:0]             payload_per_packet,
    output logic [15:0]             checksum_ip,
    output logic [NUM_CHAN-1:0]     chan_csr_rst,
    output logic [NUM_CHAN-1:0]     chan_tx_rst,
    output logic [NUM_CHAN-1:0]     chan_rx_rst,
    output logic [NUM_CHAN*64-1:0]  chan_misc_ctrl,
    input  logic [NUM_CHAN*32-1:0]  chan_tx_status,
    input  logic [NUM_CHAN*32-1:0]  chan_rx_status,
    input  logic [NUM_CHAN*ERR_W-1:0] chan_err_event,
    input  logic [NUM_CHAN-1:0]     chan_tx_pkt,
    input  logic [NUM_CHAN-1:0]     chan_rx_pkt
);

    localparam int          OFF_W = $clog2(CHAN_STRIDE_WORDS);
    localparam logic [23:0] REGSZ = 24'((CHAN_BASE_WORD + NUM_CHAN * CHAN_STRIDE_WORDS) * 8);

    logic [31:0]        word32, rel32, chan_sel;
    logic [OFF_W-1:0]   chan_off;
    logic               chan_hit;
    logic               addr_lsb_unused;
    logic [NUM_CHAN-1:0] chan_wr;
    logic [63:0]        chan_rdata [NUM_CHAN];
    logic [63:0]        scratch_q, scratch_d;
    logic [63:0]        net_q [NUM_NET_REGS];
    logic [63:0]        net_d [NUM_NET_REGS];
    logic [63:0]        rdata_q, rdata_d;
    logic               rvalid_q;

    function automatic logic [63:0] net_mask(input int unsigned idx);
        if (idx < 2) return 64'h0000_FFFF_FFFF_FFFF;
        if (idx < 5) return 64'h0000_0000_FFFF_FFFF;
        return 64'h0000_0000_0000_FFFF;
    endfunction

    assign addr_lsb_unused = ^avmm_address[2:0];
    assign word32   = 32'(avmm_address[ADDR_W-1:3]);
    assign rel32    = word32 - 32'(CHAN_BASE_WORD);
    assign chan_hit = (word32 >= 32'(CHAN_BASE_WORD)) &&
                      (rel32 < 32'(NUM_CHAN * CHAN_STRIDE_WORDS));
    assign chan_sel = rel32 / 32'(CHAN_STRIDE_WORDS);
    assign chan_off = OFF_W'(rel32 % 32'(CHAN_STRIDE_WORDS));

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        assign chan_wr[c] = avmm_write && chan_hit && (chan_sel == 32'(c));

        udp_oe_chan_csr #(
            .CHAN_IDX         (c),
            .NUM_CHAN         (NUM_CHAN),
            .STRIDE_WORDS     (CHAN_STRIDE_WORDS),
            .OFF_W            (OFF_W),
            .RST_PULSE_CYCLES (RST_PULSE_CYCLES),
            .ERR_W            (ERR_W)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .wr_i        (chan_wr[c]),
            .off_i       (chan_off),
            .wdata_i     (avmm_writedata),
            .be_i        (avmm_byteenable),
            .tx_status_i (chan_tx_status[c*32 +: 32]),
            .rx_status_i (chan_rx_status[c*32 +: 32]),
            .err_event_i (chan_err_event[c*ERR_W +: ERR_W]),
            .tx_pkt_i    (chan_tx_pkt[c]),
            .rx_pkt_i    (chan_rx_pkt[c]),
            .rdata_o     (chan_rdata[c]),
            .csr_rst_o   (chan_csr_rst[c]),
            .rx_rst_o    (chan_rx_rst[c]),
            .tx_rst_o    (chan_tx_rst[c]),
            .misc_ctrl_o (chan_misc_ctrl[c*64 +: 64])
        );
    end

    always_comb begin
        scratch_d = scratch_q;
        net_d     = net_q;
        if (avmm_write && !chan_hit) begin
            if (word32 == CSR_SCRATCH) scratch_d = be_merge(scratch_q, avmm_writedata, avmm_byteenable);
            for (int unsigned i = 0; i < NUM_NET_REGS; i++) begin
                if (word32 == CSR_FPGA_MAC + i)
                    net_d[i] = be_merge(net_q[i], avmm_writedata, avmm_byteenable) & net_mask(i);
            end
        end
    end

    // Read mux sees only current register state, so a same-cycle write is not visible.
    always_comb begin
        rdata_d = REG_RD_BADADDR_DATA;
        if (chan_hit) begin
            for (int unsigned c = 0; c < NUM_CHAN; c++) begin
                if (chan_sel == c) rdata_d = chan_rdata[c];
            end
        end else begin
            case (word32)
                CSR_DFH:      rdata_d = dfh_header(REGSZ);
                CSR_ID_LO:    rdata_d = DFH_ID_LO;
                CSR_ID_HI:    rdata_d = DFH_ID_HI;
                CSR_W3:       rdata_d = DFH_WORD3;
                CSR_W4:       rdata_d = DFH_WORD4;
                CSR_SCRATCH:  rdata_d = scratch_q;
                CSR_NUM_CHAN: rdata_d = 64'(NUM_CHAN);
                default: begin
                    for (int unsigned i = 0; i < NUM_NET_REGS; i++) begin
                        if (word32 == CSR_FPGA_MAC + i) rdata_d = net_q[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            scratch_q <= '0;
            for (int unsigned i = 0; i < NUM_NET_REGS; i++) net_q[i] <= '0;
        end else begin
            rvalid_q  <= avmm_read;
            if (avmm_read) rdata_q <= rdata_d;
            scratch_q <= scratch_d;
            for (int unsigned i = 0; i < NUM_NET_REGS; i++) net_q[i] <= net_d[i];
        end
    end

    assign avmm_waitrequest   = 1'b0;
    assign avmm_readdata      = rdata_q;
    assign avmm_readdatavalid = rvalid_q;

    assign fpga_mac_adr       = net_q[0][47:0];
    assign host_mac_adr       = net_q[1][47:0];
    assign fpga_ip_adr        = net_q[2][31:0];
    assign host_ip_adr        = net_q[3][31:0];
    assign fpga_netmask       = net_q[4][31:0];
    assign fpga_udp_port      = net_q[5][15:0];
    assign host_udp_port      = net_q[6][15:0];
    assign payload_per_packet = net_q[7][15:0];
    assign checksum_ip        = net_q[8][15:0];

endmodule

// File: tb/tb_udp_oe_csr_mchan.sv
// Directed self-checking bench for udp_oe_csr_mchan with the default two-channel map.
module tb_udp_oe_csr_mchan;
    import udp_oe_pkg::*;

    localparam int ADDR_W = 13;

    logic         clk = 1'b0;
    logic         reset;
    logic [12:0]  avmm_address;
    logic         avmm_read, avmm_write;
    logic [63:0]  avmm_writedata;
    logic [7:0]   avmm_byteenable;
    logic         avmm_waitrequest;
    logic [63:0]  avmm_readdata;
    logic         avmm_readdatavalid;
    logic [47:0]  fpga_mac_adr, host_mac_adr;
    logic [31:0]  fpga_ip_adr, host_ip_adr, fpga_netmask;
    logic [15:0]  fpga_udp_port, host_udp_port, payload_per_packet, checksum_ip;
    logic [1:0]   chan_csr_rst, chan_tx_rst, chan_rx_rst;
    logic [127:0] chan_misc_ctrl;
    logic [63:0]  chan_tx_status, chan_rx_status;
    logic [15:0]  chan_err_event;
    logic [1:0]   chan_tx_pkt, chan_rx_pkt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    udp_oe_csr_mchan #(
        .NUM_CHAN          (2),
        .CHAN_BASE_WORD    ('h20),
        .CHAN_STRIDE_WORDS ('h10),
        .ADDR_W            (ADDR_W),
        .RST_PULSE_CYCLES  (16),
        .ERR_W             (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .avmm_address       (avmm_address),
        .avmm_read          (avmm_read),
        .avmm_write         (avmm_write),
        .avmm_writedata     (avmm_writedata),
        .avmm_byteenable    (avmm_byteenable),
        .avmm_waitrequest   (avmm_waitrequest),
        .avmm_readdata      (avmm_readdata),
        .avmm_readdatavalid (avmm_readdatavalid),
        .fpga_mac_adr       (fpga_mac_adr),
        .host_mac_adr       (host_mac_adr),
        .fpga_ip_adr        (fpga_ip_adr),
        .host_ip_adr        (host_ip_adr),
        .fpga_netmask       (fpga_netmask),
        .fpga_udp_port      (fpga_udp_port),
        .host_udp_port      (host_udp_port),
        .payload_per_packet (payload_per_packet),
        .checksum_ip        (checksum_ip),
        .chan_csr_rst       (chan_csr_rst),
        .chan_tx_rst        (chan_tx_rst),
        .chan_rx_rst        (chan_rx_rst),
        .chan_misc_ctrl     (chan_misc_ctrl),
        .chan_tx_status     (chan_tx_status),
        .chan_rx_status     (chan_rx_status),
        .chan_err_event     (chan_err_event),
        .chan_tx_pkt        (chan_tx_pkt),
        .chan_rx_pkt        (chan_rx_pkt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int word, input logic [63:0] d, input logic [7:0] b);
        @(negedge clk);
        avmm_address    = ADDR_W'(word * 8);
        avmm_write      = 1'b1;
        avmm_writedata  = d;
        avmm_byteenable = b;
        @(negedge clk);
        avmm_write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int word, input logic [63:0] exp);
        @(negedge clk);
        avmm_address = ADDR_W'(word * 8);
        avmm_read    = 1'b1;
        @(negedge clk);
        avmm_read = 1'b0;
        check({tag, "_vld"}, 64'(avmm_readdatavalid), 64'd1);
        check(tag, avmm_readdata, exp);
    endtask

    task automatic pulse_run(input int rewrite_at, output int n_csr, output int n_rx, output int n_tx,
                             output int last_hi, output int n_other);
        @(negedge clk);
        avmm_address    = ADDR_W'('h31 * 8);
        avmm_writedata  = 64'h7;
        avmm_byteenable = 8'hFF;
        avmm_write      = 1'b1;
        @(negedge clk);
        avmm_write = 1'b0;
        n_csr = 0; n_rx = 0; n_tx = 0; n_other = 0; last_hi = -1;
        for (int i = 0; i < 40; i++) begin
            if (chan_csr_rst[1]) n_csr++;
            if (chan_rx_rst[1])  n_rx++;
            if (chan_tx_rst[1]) begin n_tx++; last_hi = i; end
            if (chan_csr_rst[0] | chan_rx_rst[0] | chan_tx_rst[0]) n_other++;
            avmm_write = (i == rewrite_at);
            @(negedge clk);
        end
        avmm_write = 1'b0;
    endtask

    initial begin : main
        int        n_csr, n_rx, n_tx, last_hi, n_other, seen;
        chan_csr_t frc;

        reset = 1'b1;
        avmm_address = '0; avmm_read = 1'b0; avmm_write = 1'b0;
        avmm_writedata = '0; avmm_byteenable = '0;
        chan_tx_status = {32'hCAFE_0001, 32'hCAFE_0000};
        chan_rx_status = {32'h5555_0001, 32'h5555_0000};
        chan_err_event = '0; chan_tx_pkt = '0; chan_rx_pkt = '0;
        repeat (3) @(negedge clk);

        check("rst_rdata",  avmm_readdata, 64'd0);
        check("rst_rvalid", 64'(avmm_readdatavalid), 64'd0);
        check("rst_pulses", 64'({chan_csr_rst, chan_tx_rst, chan_rx_rst}), 64'd0);
        check("rst_mac",    64'(fpga_mac_adr), 64'd0);
        check("rst_misc",   chan_misc_ctrl[63:0] | chan_misc_ctrl[127:64], 64'd0);
        check("waitreq",    64'(avmm_waitrequest), 64'd0);
        reset = 1'b0;

        // Map discovery
        rd_chk("num_chan",   6,     64'd2);
        rd_chk("dfh",        0,     64'h1010_0100_0200_10A5);
        rd_chk("word3",      3,     64'h18);
        rd_chk("info0",      'h20,  64'h0000_0000_0000_0010);
        rd_chk("info1",      'h30,  64'h0000_0000_0001_0110);
        rd_chk("past_last",  'h40,  REG_RD_BADADDR_DATA);
        rd_chk("gap",        'h10,  REG_RD_BADADDR_DATA);
        rd_chk("chan_off7",  'h27,  REG_RD_BADADDR_DATA);
        rd_chk("status1",    'h32,  64'hCAFE_0001_5555_0001);

        // Byteenable and field widths
        wr(7, 64'h0000_AABB_CCDD_EEFF, 8'h0F);
        rd_chk("mac_be",     7,     64'h0000_0000_CCDD_EEFF);
        check("mac_out",     64'(fpga_mac_adr), 64'h0000_0000_CCDD_EEFF);
        wr(9, 64'hFFFF_FFFF_C0A8_0001, 8'hFF);
        rd_chk("ip_width",   9,     64'h0000_0000_C0A8_0001);
        check("ip_out",      64'(fpga_ip_adr), 64'h0000_0000_C0A8_0001);
        wr(12, 64'hFFFF_FFFF_FFFF_1234, 8'hFF);
        check("port_out",    64'(fpga_udp_port), 64'h1234);
        wr(6, 64'h55, 8'hFF);
        rd_chk("num_chan_ro", 6,    64'd2);

        // Read and write to the same word in one cycle
        wr(5, 64'h1111_2222_3333_4444, 8'hFF);
        @(negedge clk);
        avmm_address = ADDR_W'(5 * 8);
        avmm_writedata = 64'hAAAA_BBBB_CCCC_DDDD; avmm_byteenable = 8'hFF;
        avmm_read = 1'b1; avmm_write = 1'b1;
        @(negedge clk);
        avmm_read = 1'b0; avmm_write = 1'b0;
        check("rw_same_pre", avmm_readdata, 64'h1111_2222_3333_4444);
        rd_chk("rw_same_post", 5, 64'hAAAA_BBBB_CCCC_DDDD);
        wr(5, 64'h0, 8'hF0);
        rd_chk("scratch_be", 5, 64'h0000_0000_CCCC_DDDD);

        // Reset pulses
        pulse_run(-1, n_csr, n_rx, n_tx, last_hi, n_other);
        check("pulse_csr",  64'(n_csr), 64'd16);
        check("pulse_rx",   64'(n_rx),  64'd16);
        check("pulse_tx",   64'(n_tx),  64'd16);
        check("pulse_last", 64'(last_hi), 64'd15);
        check("pulse_ch0",  64'(n_other), 64'd0);
        pulse_run(9, n_csr, n_rx, n_tx, last_hi, n_other);
        check("extend_tx",   64'(n_tx), 64'd26);
        check("extend_csr",  64'(n_csr), 64'd26);
        check("extend_last", 64'(last_hi), 64'd25);
        wr('h21, 64'h0, 8'hFF);
        check("zero_wr", 64'({chan_csr_rst, chan_tx_rst, chan_rx_rst}), 64'd0);
        wr('h31, 64'h2, 8'hFF);
        rd_chk("rst_level", 'h31, 64'h2);
        repeat (20) @(negedge clk);
        rd_chk("rst_done",  'h31, 64'h0);

        // Packet counters
        frc = '0;
        frc.tx_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        force dut.g_chan[1].u_chan.st_q = frc;
        @(negedge clk);
        release dut.g_chan[1].u_chan.st_q;
        rd_chk("tx_preload", 'h35, 64'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chan_tx_pkt[1] = 1'b1;
            @(negedge clk); chan_tx_pkt[1] = 1'b0;
        end
        rd_chk("tx_sat", 'h35, 64'hFFFF_FFFF);
        @(negedge clk);
        avmm_address = ADDR_W'('h35 * 8); avmm_writedata = '0; avmm_byteenable = 8'hFF;
        avmm_write = 1'b1; chan_tx_pkt[1] = 1'b1;
        @(negedge clk);
        avmm_write = 1'b0; chan_tx_pkt[1] = 1'b0;
        rd_chk("tx_clr_pulse", 'h35, 64'd1);
        @(negedge clk); chan_rx_pkt[0] = 1'b1;
        @(negedge clk);
        @(negedge clk); chan_rx_pkt[0] = 1'b0;
        rd_chk("rx_cnt", 'h26, 64'd2);
        wr('h26, 64'h0, 8'hFF);
        rd_chk("rx_clr", 'h26, 64'd0);

        // Sticky errors
        @(negedge clk);
        avmm_address = ADDR_W'('h24 * 8); avmm_writedata = 64'h08; avmm_byteenable = 8'hFF;
        avmm_write = 1'b1; chan_err_event[3] = 1'b1;
        @(negedge clk);
        avmm_write = 1'b0; chan_err_event[3] = 1'b0;
        rd_chk("err_set_wins", 'h24, 64'h08);
        wr('h24, 64'h08, 8'hFF);
        rd_chk("err_w1c", 'h24, 64'h00);
        @(negedge clk); chan_err_event[13] = 1'b1;
        @(negedge clk); chan_err_event[13] = 1'b0;
        rd_chk("err_ch1", 'h34, 64'h20);
        rd_chk("err_ch0_clean", 'h24, 64'h00);

        // Per-channel control
        wr('h23, 64'h0123_4567_89AB_CDEF, 8'hFF);
        check("misc0_out", chan_misc_ctrl[63:0], 64'h0123_4567_89AB_CDEF);
        wr('h33, 64'hFFFF_FFFF_FFFF_FFFF, 8'h03);
        check("misc1_out", chan_misc_ctrl[127:64], 64'h0000_0000_0000_FFFF);
        rd_chk("misc1_rd", 'h33, 64'h0000_0000_0000_FFFF);

        // Async reset with a pulse active and a read in flight
        wr('h21, 64'h1, 8'hFF);
        @(negedge clk);
        avmm_address = ADDR_W'(5 * 8);
        avmm_read = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_vld",   64'(avmm_readdatavalid), 64'd1);
        check("pre_rst_pulse", 64'(chan_csr_rst[0]), 64'd1);
        reset = 1'b1;
        #1;
        check("arst_vld",   64'(avmm_readdatavalid), 64'd0);
        check("arst_rdata", avmm_readdata, 64'd0);
        check("arst_pulse", 64'({chan_csr_rst, chan_tx_rst, chan_rx_rst}), 64'd0);
        check("arst_mac",   64'(fpga_mac_adr), 64'd0);
        check("arst_misc",  chan_misc_ctrl[63:0], 64'd0);
        @(negedge clk);
        avmm_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (avmm_readdatavalid || (chan_csr_rst != 2'b00)) seen++;
        end
        check("post_rst_quiet", 64'(seen), 64'd0);
        rd_chk("post_rst_scratch", 5, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
